icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//   Direct-mapped, one-word-per-block instruction cache between the pipelined datapath fetch port and the memory controller.
//   Serves imemREN/imemaddr with a same-cycle ihit/imemload on a hit.
//   Fills a miss with a single-word iREN request to memory, then hits on the following cycle.
//   Keeps hit and miss counters for CPU tracker statistics.
// PARAMETERS
//   SETS   16  number of frames; power of two, at least 2
//   IDX_W  4   log2(SETS); index = imemaddr[IDX_W+1:2], tag = imemaddr[31:IDX_W+2]
// PORTS
//   CLK         in   1   single clock, rising edge
//   RST         in   1   asynchronous, active-high reset
//   imemREN     in   1   datapath fetch request
//   imemaddr    in   32  fetch byte address; bits [1:0] ignored
//   ihit        out  1   imemload valid for imemaddr this cycle
//   imemload    out  32  instruction word
//   iREN        out  1   memory read request
//   iaddr       out  32  memory word address, bits [1:0] = 0
//   iwait       in   1   memory busy; iload valid on any cycle iREN=1 and iwait=0
//   iload       in   32  memory read data
//   hit_count   out  32  cycles with ihit=1
//   miss_count  out  32  completed miss fills
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high (CLK, RST).
//   Reset values
//     all frame valid bits 0; state IDLE; fill address register 0; both counters 0.
//     Combinational outputs are consequently ihit=0, iREN=0, iaddr=0, imemload=0.
//   Lookup (combinational)
//     hit = imemREN & valid[idx] & (tag[idx]==addr_tag) & (state==IDLE).
//     ihit=hit; imemload = hit ? data[idx] : 0.
//   FSM: IDLE, FETCH
//     IDLE
//       imemREN & !hit -> latch {addr_tag,idx} into fill register; go to FETCH.
//       Otherwise stay in IDLE.
//     FETCH
//       iREN=1; iaddr = {fill_tag, fill_idx, 2'b00}, held stable for the whole state.
//       iwait=1 -> stay in FETCH.
//       iwait=0 -> at the edge write data[fill_idx]=iload, tag=fill_tag, valid=1; miss_count+1; go to IDLE.
//     iREN=0 and iaddr=0 in IDLE.
//   Latency
//     hit: 0 cycles.
//     miss: 1 detect cycle + N memory wait cycles + 1 fill edge; ihit asserts the cycle after the fill.
//     Minimum miss to ihit = 2 cycles when iwait=0 on the first FETCH cycle.
//   Redirect / abandon
//     A change of imemaddr or a drop of imemREN during FETCH does not abort the fill.
//     The latched address completes, then IDLE re-evaluates the current request.
//     No ihit is given during FETCH, even if the new address would hit.
//   Conflict: a fill overwrites any valid frame at fill_idx; no write-back (read-only cache).
//   Counters: hit_count increments on every CLK edge with ihit=1; both counters wrap modulo 2^32.
//   Reset mid-FETCH: iREN drops immediately (async); the fill is discarded and valids are cleared.
// STRUCTURE
//   cpu_types_pkg gains:
//     icachef_t: packed {tag[31:IDX_W+2], idx, bytoff[1:0]} address breakdown
//     icache_frame_t: {valid, tag, data}
//     icache_state_t: enum {IDLE, FETCH}
//   Sub-module icache_frame_array (SETS x icache_frame_t, async read, sync write, async clear) is natural.
//   The FSM, lookup and counters stay in icache_direct.
// TESTING
//   Cold miss
//     Stimulus: RST pulse, imemREN=1, imemaddr=0x40, iwait=1 for 3 cycles then 0, iload=0x8C220004.
//     Required: iREN=1 with iaddr=0x40 during FETCH; ihit=1 with imemload=0x8C220004 on the next cycle; miss_count=1.
//   Repeat hit
//     Stimulus: re-request 0x40 for 5 cycles.
//     Required: ihit=1 every cycle, iREN=0, hit_count increases by 5.
//   Conflict eviction (SETS=16)
//     Stimulus: fill 0x40, then request 0x80 (same idx=0, different tag); fill with iload=0x11111111; request 0x40 again.
//     Required: 0x80 misses and then hits; 0x40 misses again; miss_count=3.
//   Redirect during FETCH
//     Stimulus: miss on 0x100, then change imemaddr to 0x200 while iwait=1.
//     Required: iaddr stays 0x100 until iwait=0; 0x100 is filled; 0x200 then starts its own miss.
//     Required: ihit is never asserted for 0x200 using the 0x100 data.
//   Reset mid-fill
//     Stimulus: assert RST in FETCH while iwait=1.
//     Required: iREN=0 in the same cycle; after release, the previously hit 0x40 misses; both counters are 0.
//   imemREN low
//     Stimulus: imemREN=0 with an arbitrary imemaddr.
//     Required: ihit=0, iREN=0, counters unchanged.

Source files
------------

// File: rtl/icache_direct_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_direct_pkg
// Brief   : Shared types and default geometry for the direct-mapped I-cache.
// Revision: 1.0 - initial release
// ============================================================================
package icache_direct_pkg;

    localparam int C_SETS  = 16;
    localparam int C_IDX_W = 4;
    localparam int C_TAG_W = 32 - C_IDX_W - 2;

    typedef struct packed {
        logic [C_TAG_W-1:0] tag;
        logic [C_IDX_W-1:0] idx;
        logic [1:0]         bytoff;
    } icachef_t;

    typedef struct packed {
        logic               valid;
        logic [C_TAG_W-1:0] tag;
        logic [31:0]        data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_frame_array.sv
`default_nettype none
// ============================================================================
// Module  : icache_frame_array
// Brief   : SETS frames of {valid, tag, data}; async read, sync write,
//           valid bits cleared asynchronously by rst.
// Revision: 1.0 - initial release
// ============================================================================
module icache_frame_array #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];

    // Only the valid bits need reset; tag/data are never observed while invalid.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_frame
        logic w_wr_sel;
        assign w_wr_sel = i_wr_en && (i_wr_idx == IDX_W'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid[gi] <= 1'b0;
            end else if (w_wr_sel) begin
                r_valid[gi] <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr_sel) begin
                r_tag[gi]  <= i_wr_tag;
                r_data[gi] <= i_wr_data;
            end
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module  : icache_direct
// Brief   : Direct-mapped, one-word-per-block instruction cache with
//           same-cycle hit, single-word miss fill and hit/miss counters.
// Revision: 1.0 - initial release
// ============================================================================
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int SETS  = C_SETS,
    parameter int IDX_W = C_IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int C_LOC_TAG_W = 30 - IDX_W;

    icache_state_t          r_state;
    logic [C_LOC_TAG_W-1:0] r_fill_tag;
    logic [IDX_W-1:0]       r_fill_idx;
    logic [31:0]            r_hit_count;
    logic [31:0]            r_miss_count;

    logic [IDX_W-1:0]       w_idx;
    logic [C_LOC_TAG_W-1:0] w_tag;
    logic                   w_rd_valid;
    logic [C_LOC_TAG_W-1:0] w_rd_tag;
    logic [31:0]            w_rd_data;
    logic                   w_hit;
    logic                   w_fill_done;
    logic                   w_unused_bytoff;

    assign w_idx           = imemaddr[IDX_W+1:2];
    assign w_tag           = imemaddr[31:IDX_W+2];
    assign w_unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (C_LOC_TAG_W)
    ) u_frames (
        .clk        (CLK),
        .rst        (RST),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill_done),
        .i_wr_idx   (r_fill_idx),
        .i_wr_tag   (r_fill_tag),
        .i_wr_data  (iload)
    );

    // Hits are suppressed while a fill is outstanding, even for a redirected address.
    assign w_hit       = imemREN && w_rd_valid && (w_rd_tag == w_tag) && (r_state == IDLE);
    assign w_fill_done = (r_state == FETCH) && !iwait;

    assign ihit       = w_hit;
    assign imemload   = w_hit ? w_rd_data : 32'h0;
    assign iREN       = (r_state == FETCH);
    assign iaddr      = (r_state == FETCH) ? {r_fill_tag, r_fill_idx, 2'b00} : 32'h0;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_fill_tag <= '0;
            r_fill_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_hit) begin
                        r_fill_tag <= w_tag;
                        r_fill_idx <= w_idx;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'h1;
            end
            if (w_fill_done) begin
                r_miss_count <= r_miss_count + 32'h1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_direct
// Brief   : Self-checking bench for icache_direct: directed vector table,
//           corner sequences and randomized traffic against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        iwait = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    icache_direct #(
        .SETS  (16),
        .IDX_W (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        wt;
        logic [31:0] load;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic ren, input logic [31:0] a, input logic w, input logic [31:0] l,
                       input logic eh, input logic [31:0] el, input logic er, input logic [31:0] ea);
        vec_t v;
        v.ren = ren; v.addr = a; v.wt = w; v.load = l;
        v.e_hit = eh; v.e_load = el; v.e_iren = er; v.e_iaddr = ea;
        vt.push_back(v);
    endtask

    // One clock cycle: inputs are driven just after posedge, outputs sampled on negedge.
    task automatic cyc(input string nm, input logic ren, input logic [31:0] a, input logic w,
                       input logic [31:0] l, input logic eh, input logic [31:0] el,
                       input logic er, input logic [31:0] ea);
        imemREN = ren; imemaddr = a; iwait = w; iload = l;
        @(negedge CLK);
        chk({nm, ".ihit"},     32'(ihit),  32'(eh));
        chk({nm, ".imemload"}, imemload,   el);
        chk({nm, ".iREN"},     32'(iREN),  32'(er));
        chk({nm, ".iaddr"},    iaddr,      ea);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Reference model: each frame remembers the full word address it holds.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [29:0] m_fill;
    logic [31:0] m_hits;
    logic [31:0] m_miss;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0; m_fill = '0; m_hits = '0; m_miss = '0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [29:0] word;
        logic        rren;
        logic        rw;
        logic [31:0] rl;
        logic        eh;
        int          slot;

        // Reset state with a request already pending
        imemREN = 1'b1; imemaddr = 32'h40;
        @(negedge CLK);
        chk("rst.ihit",       32'(ihit), 32'h0);
        chk("rst.imemload",   imemload,  32'h0);
        chk("rst.iREN",       32'(iREN), 32'h0);
        chk("rst.iaddr",      iaddr,     32'h0);
        chk("rst.hit_count",  hit_count, 32'h0);
        chk("rst.miss_count", miss_count, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Cold miss, repeat hits, conflict eviction, imemREN low
        add(1, 32'h40, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        add(1, 32'h40, 0, 32'h8C220004, 0, 32'h0,        1, 32'h40);
        for (int i = 0; i < 6; i++)
            add(1, 32'h40, 0, 32'h0,    1, 32'h8C220004, 0, 32'h0);
        add(1, 32'h80, 0, 32'h11111111, 0, 32'h0,        0, 32'h0);
        add(1, 32'h80, 0, 32'h11111111, 0, 32'h0,        1, 32'h80);
        add(1, 32'h80, 0, 32'h0,        1, 32'h11111111, 0, 32'h0);
        add(1, 32'h40, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 32'h40, 0, 32'h8C220004, 0, 32'h0,        1, 32'h40);
        add(1, 32'h43, 0, 32'h0,        1, 32'h8C220004, 0, 32'h0);
        add(0, 32'h40, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        add(0, 32'hDEADBEEF, 1, 32'h0,  0, 32'h0,        0, 32'h0);

        foreach (vt[i]) begin
            cyc($sformatf("vec%0d", i), vt[i].ren, vt[i].addr, vt[i].wt, vt[i].load,
                vt[i].e_hit, vt[i].e_load, vt[i].e_iren, vt[i].e_iaddr);
        end
        chk("tbl.hit_count",  hit_count,  32'd8);
        chk("tbl.miss_count", miss_count, 32'd3);

        // Redirect during FETCH: 0x100 completes, then 0x200 misses on its own
        cyc("redir0", 1, 32'h100, 1, 32'h0,        0, 32'h0, 0, 32'h0);
        cyc("redir1", 1, 32'h200, 1, 32'h0,        0, 32'h0, 1, 32'h100);
        cyc("redir2", 1, 32'h200, 1, 32'h0,        0, 32'h0, 1, 32'h100);
        cyc("redir3", 1, 32'h200, 0, 32'hAAAA0100, 0, 32'h0, 1, 32'h100);
        chk("redir.miss_count", miss_count, 32'd4);
        cyc("redir4", 1, 32'h200, 0, 32'h0,        0, 32'h0, 0, 32'h0);
        cyc("redir5", 1, 32'h200, 0, 32'hBBBB0200, 0, 32'h0, 1, 32'h200);
        cyc("redir6", 1, 32'h200, 0, 32'h0,        1, 32'hBBBB0200, 0, 32'h0);
        chk("redir.miss_count2", miss_count, 32'd5);
        chk("redir.hit_count",   hit_count,  32'd9);

        // Reset mid-fill
        cyc("rmf0", 1, 32'h44, 0, 32'h0,        0, 32'h0, 0, 32'h0);
        cyc("rmf1", 1, 32'h44, 0, 32'h44444444, 0, 32'h0, 1, 32'h44);
        cyc("rmf2", 1, 32'h44, 0, 32'h0,        1, 32'h44444444, 0, 32'h0);
        cyc("rmf3", 1, 32'h300, 1, 32'h0,       0, 32'h0, 0, 32'h0);
        imemaddr = 32'h300; iwait = 1'b1;
        #1;
        chk("rmf.pre.iREN", 32'(iREN), 32'h1);
        RST = 1'b1;
        #1;
        chk("rmf.iREN",       32'(iREN), 32'h0);
        chk("rmf.iaddr",      iaddr,     32'h0);
        chk("rmf.hit_count",  hit_count, 32'h0);
        chk("rmf.miss_count", miss_count, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc("rmf4", 1, 32'h44, 1, 32'h0,        0, 32'h0, 0, 32'h0);
        cyc("rmf5", 1, 32'h44, 0, 32'h44444444, 0, 32'h0, 1, 32'h44);
        cyc("rmf6", 1, 32'h44, 0, 32'h0,        1, 32'h44444444, 0, 32'h0);
        chk("rmf.miss_after", miss_count, 32'd1);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            rren = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0)
                ra = $urandom;
            else
                ra = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3));
            rw = ($urandom_range(0, 9) < 4);
            rl = $urandom;
            imemREN = rren; imemaddr = ra; iwait = rw; iload = rl;
            @(negedge CLK);

            word = ra[31:2];
            slot = int'(word % 30'd16);
            eh   = !m_busy && rren && m_valid[slot] && (m_word[slot] == word);
            chk("rnd.ihit",       32'(ihit),  32'(eh));
            chk("rnd.imemload",   imemload,   eh ? m_data[slot] : 32'h0);
            chk("rnd.iREN",       32'(iREN),  32'(m_busy));
            chk("rnd.iaddr",      iaddr,      m_busy ? {m_fill, 2'b00} : 32'h0);
            chk("rnd.hit_count",  hit_count,  m_hits);
            chk("rnd.miss_count", miss_count, m_miss);

            if (eh) m_hits = m_hits + 32'h1;
            if (m_busy) begin
                if (!rw) begin
                    slot = int'(m_fill % 30'd16);
                    m_valid[slot] = 1'b1;
                    m_word[slot]  = m_fill;
                    m_data[slot]  = rl;
                    m_miss = m_miss + 32'h1;
                    m_busy = 1'b0;
                end
            end else if (rren && !eh) begin
                m_busy = 1'b1;
                m_fill = word;
            end

            @(posedge CLK);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
